// File: rtl/icache_axi_rd_bridge_pkg.sv
// icache_axi_rd_bridge_pkg: shared FSM state encoding, AXI constants and default AXI id
package icache_axi_rd_bridge_pkg;
  typedef enum logic [1:0] {IDLE, AR, R, RESP} state_e;
  localparam logic [2:0] SIZE_8B        = 3'b011;
  localparam logic [1:0] BURST_INCR     = 2'b01;
  localparam logic [1:0] RESP_OKAY      = 2'b00;
  localparam logic [1:0] RESP_SLVERR    = 2'b10;
  localparam logic [1:0] RESP_DECERR    = 2'b11;
  localparam int         DEFAULT_AXI_ID = 0;
endpackage

// File: rtl/icache_axi_rd_bridge.sv
// icache_axi_rd_bridge: turns one I-cache refill request into one single-beat AXI4 read.
// Ports: clk/rst (sync, active-high); req_ena/req_addr from the cache miss logic;
// rsp_valid/rsp_data/rsp_err one-cycle response back to the cache; busy while not IDLE;
// ar*/r* AXI4 read channels of the instruction master port.
// Optional macro ICACHE_AXI_RD_BRIDGE_TIMEOUT_EN adds an 8-bit watchdog that forces an
// error response after TIMEOUT stalled cycles in AR or R.
import icache_axi_rd_bridge_pkg::*;
module icache_axi_rd_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int ID_W    = 4,
  parameter int AXI_ID  = DEFAULT_AXI_ID,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_ena,
  input  logic [63:0]       req_addr,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [ID_W-1:0]   arid,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic [ID_W-1:0]   rid
);
  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [1:0]          resp_q, resp_d;
  logic                got_q, got_d;
  logic                unused_ok;
`ifdef ICACHE_AXI_RD_BRIDGE_TIMEOUT_EN
  logic [7:0]          cnt_q, cnt_d;
`endif
  // RESP always returns to IDLE without looking at req_ena, so a request still held
  // during the response cycle cannot launch a duplicate transaction.
  always_comb begin
    state_d  = state_q;
    araddr_d = araddr_q;
    data_d   = data_q;
    resp_d   = resp_q;
    got_d    = got_q;
    case (state_q)
      IDLE: if (req_ena) begin
        state_d  = AR;
        araddr_d = {req_addr[ADDR_W-1:3], 3'b000};
        data_d   = '0;
        resp_d   = RESP_OKAY;
        got_d    = 1'b0;
      end
      AR: state_d = arready ? R : AR;
      R: if (rvalid) begin
        if (!got_q && rid == ID_W'(AXI_ID)) begin
          data_d = rdata;
          resp_d = rresp;
          got_d  = 1'b1;
        end
        state_d = rlast ? RESP : R;
      end
      default: state_d = IDLE;
    endcase
`ifdef ICACHE_AXI_RD_BRIDGE_TIMEOUT_EN
    cnt_d = cnt_q;
    if (state_q == IDLE || (state_q == AR && arready)) cnt_d = '0;
    else if ((state_q == AR && !arready) || (state_q == R && !rvalid)) begin
      cnt_d = cnt_q + 8'd1;
      if (cnt_d == 8'(TIMEOUT)) begin
        state_d = RESP;
        resp_d  = RESP_SLVERR;
        data_d  = '0;
      end
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      araddr_q <= '0;
      data_q   <= '0;
      resp_q   <= RESP_OKAY;
      got_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      araddr_q <= araddr_d;
      data_q   <= data_d;
      resp_q   <= resp_d;
      got_q    <= got_d;
    end
  end
`ifdef ICACHE_AXI_RD_BRIDGE_TIMEOUT_EN
  always_ff @(posedge clk) cnt_q <= rst ? 8'd0 : cnt_d;
`endif
  // rresp[1] covers both SLVERR and DECERR; error responses never leak data.
  assign rsp_valid = state_q == RESP;
  assign rsp_err   = rsp_valid && resp_q[1];
  assign rsp_data  = (rsp_valid && !resp_q[1]) ? data_q : '0;
  assign busy      = state_q != IDLE;
  assign arvalid   = state_q == AR;
  assign rready    = state_q == R;
  assign araddr    = araddr_q;
  assign arid      = ID_W'(AXI_ID);
  assign arlen     = 8'd0;
  assign arsize    = SIZE_8B;
  assign arburst   = BURST_INCR;
  assign unused_ok = ^{req_addr[63:ADDR_W], req_addr[2:0], TIMEOUT[0]};
endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// tb_icache_axi_rd_bridge: directed scoreboard bench for the I-cache AXI read bridge
module tb_icache_axi_rd_bridge;
  logic        clk = 0, rst = 1, req_ena = 0;
  logic [63:0] req_addr = 0;
  logic        rsp_valid, rsp_err, busy, arvalid, rready;
  logic [63:0] rsp_data;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arready = 0, rvalid = 0, rlast = 0;
  logic [63:0] rdata = 0;
  logic [1:0]  rresp = 0;
  logic [3:0]  rid = 0;
  int          passed = 0, total = 0;
  logic [64:0] exp_rsp[$];
  logic [31:0] exp_ar[$];
  logic [64:0] me;
  logic [31:0] ma, prev_addr = 0;
  bit          chk_stable = 0, prev_wait = 0;

  icache_axi_rd_bridge #(.ADDR_W(32), .DATA_W(64), .ID_W(4), .AXI_ID(0), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_ena(req_ena), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .rresp(rresp), .rlast(rlast), .rid(rid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) $display("FAIL %s: got %h want %h", n, a, e);
    else passed++;
  endtask

  always @(negedge clk) if (!rst) begin
    if (rsp_valid) begin
      if (exp_rsp.size() == 0) begin
        total++;
        $display("FAIL rsp_unexpected: got rsp_valid data=%h err=%b want none", rsp_data, rsp_err);
      end else begin
        me = exp_rsp.pop_front();
        chk("rsp_data", rsp_data, me[63:0]);
        chk("rsp_err", rsp_err, me[64]);
      end
    end
    if (arvalid && arready) begin
      if (exp_ar.size() == 0) begin
        total++;
        $display("FAIL ar_unexpected: got handshake araddr=%h want none", araddr);
      end else begin
        ma = exp_ar.pop_front();
        chk("araddr", araddr, ma);
        chk("arlen", arlen, 0);
        chk("arsize", arsize, 3);
        chk("arburst", arburst, 1);
        chk("arid", arid, 0);
      end
    end
    if (chk_stable && prev_wait) begin
      chk("ar_hold", arvalid, 1);
      chk("ar_stable", araddr, prev_addr);
    end
    prev_wait = arvalid && !arready;
    prev_addr = araddr;
  end

  task automatic txn(input logic [63:0] a, input logic [31:0] ea, input int ad, input int rd,
                     input bit xb, input logic [3:0] xr, input logic [63:0] xd,
                     input logic [63:0] d, input logic [1:0] rr,
                     input bit ee, input logic [63:0] ed, input bit hold);
    exp_ar.push_back(ea);
    exp_rsp.push_back({ee, ed});
    req_ena = 1; req_addr = a;
    for (int i = 0; i < 20 && !arvalid; i++) begin @(posedge clk); #1; end
    chk("ar_seen", arvalid, 1);
    req_addr = 64'hFFFF_FFFF_FFFF_FFF8;
    repeat (ad) begin @(posedge clk); #1; end
    arready = 1; @(posedge clk); #1; arready = 0;
    chk("r_ready", rready, 1);
    if (xb) begin
      rvalid = 1; rlast = 0; rid = xr; rdata = xd; rresp = 0;
      @(posedge clk); #1; rvalid = 0;
    end
    repeat (rd) begin @(posedge clk); #1; end
    rvalid = 1; rlast = 1; rid = 0; rdata = d; rresp = rr;
    @(posedge clk); #1; rvalid = 0; rlast = 0;
    chk("rsp_pulse", rsp_valid, 1);
    if (!hold) req_ena = 0;
    @(posedge clk); #1;
    chk("rsp_once", rsp_valid, 0);
    chk("busy_clear", busy, 0);
    chk("no_rereq", arvalid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_data", rsp_data, 0);
    rst = 0;
    rvalid = 1; rlast = 1; rdata = 64'h5555;
    @(posedge clk); #1;
    chk("idle_rready", rready, 0);
    chk("idle_busy", busy, 0);
    rvalid = 0; rlast = 0;
    // basic hit path
    txn(64'h8000_0004, 32'h8000_0000, 0, 0, 0, 0, 0, 64'h1111_2222_3333_4444, 2'b00, 0, 64'h1111_2222_3333_4444, 0);
    // backpressure on both channels
    chk_stable = 1;
    txn(64'h8000_1010, 32'h8000_1010, 5, 7, 0, 0, 0, 64'hCAFE_F00D_0000_0001, 2'b00, 0, 64'hCAFE_F00D_0000_0001, 0);
    chk_stable = 0;
    // error responses
    txn(64'h0000_0040, 32'h0000_0040, 1, 2, 0, 0, 0, 64'hDEAD, 2'b10, 1, 64'h0, 0);
    txn(64'h0000_0047, 32'h0000_0040, 0, 0, 0, 0, 0, 64'hBEEF, 2'b11, 1, 64'h0, 0);
    // foreign-id beat dropped, then first matching beat captured over a later one
    txn(64'h1234_567F, 32'h1234_5678, 0, 1, 1, 4'd5, 64'hBAD, 64'h0123_4567_89AB_CDEF, 2'b00, 0, 64'h0123_4567_89AB_CDEF, 0);
    txn(64'h2000_0010, 32'h2000_0010, 0, 0, 1, 4'd0, 64'hAAAA, 64'hBBBB, 2'b00, 0, 64'hAAAA, 0);
    // back-to-back: request held through RESP must not relaunch until seen in IDLE
    txn(64'h8000_0000, 32'h8000_0000, 0, 0, 0, 0, 0, 64'h0A0A, 2'b00, 0, 64'h0A0A, 1);
    txn(64'h8000_0008, 32'h8000_0008, 0, 0, 0, 0, 0, 64'h0B0B, 2'b00, 0, 64'h0B0B, 0);
    // reset while in R
    exp_ar.push_back(32'h8000_0100);
    req_ena = 1; req_addr = 64'h8000_0100;
    for (int i = 0; i < 20 && !arvalid; i++) begin @(posedge clk); #1; end
    chk("midr_ar_seen", arvalid, 1);
    arready = 1; @(posedge clk); #1; arready = 0;
    chk("midr_rready", rready, 1);
    rst = 1; req_ena = 0;
    @(posedge clk); #1; rst = 0;
    chk("midr_arvalid", arvalid, 0);
    chk("midr_rready0", rready, 0);
    chk("midr_busy", busy, 0);
    chk("midr_rsp_valid", rsp_valid, 0);
    txn(64'h8000_0200, 32'h8000_0200, 0, 0, 0, 0, 0, 64'h7777, 2'b00, 0, 64'h7777, 0);
    // stuck AR channel
    req_ena = 1; req_addr = 64'h9000_0000; arready = 0;
`ifdef ICACHE_AXI_RD_BRIDGE_TIMEOUT_EN
    exp_rsp.push_back({1'b1, 64'h0});
    @(posedge clk); #1;
    repeat (15) begin @(posedge clk); #1; end
    chk("to_early", rsp_valid, 0);
    @(posedge clk); #1;
    chk("to_fire", rsp_valid, 1);
    chk("to_err", rsp_err, 1);
    req_ena = 0;
    @(posedge clk); #1;
    chk("to_busy", busy, 0);
`else
    repeat (40) begin @(posedge clk); #1; end
    chk("no_to_busy", busy, 1);
    chk("no_to_arvalid", arvalid, 1);
    rst = 1; req_ena = 0;
    @(posedge clk); #1; rst = 0;
`endif
    repeat (3) begin @(posedge clk); #1; end
    chk("rsp_q_empty", exp_rsp.size(), 0);
    chk("ar_q_empty", exp_ar.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
